// File: rtl/mc_ctrl_fsm.sv
// Control sequencer for the multi-cycle core: steps the shared datapath
// through IF/ID/EXE/MEM/WB one instruction at a time, absorbs a fixed SRAM
// read latency and counts retired instructions.
module mc_ctrl_fsm #(
  parameter int SRAM_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             is_br,
  input  logic             is_jmp,
  input  logic             is_ld,
  input  logic             is_st,
  input  logic             gr_we_dec,
  input  logic             br_taken,
  output logic [2:0]       state,
  output logic             inst_sram_en,
  output logic             ir_we,
  output logic             data_sram_en,
  output logic             data_sram_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel_br,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  // Last wait-counter value of an SRAM access (data returns in this cycle).
  localparam logic [2:0] LAT_LAST = 3'(SRAM_LAT - 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;

  logic cnt_inc;
  logic ien_c, irwe_c, den_c, dwe_c, rfwe_c, pcwe_c, sel_c, ret_c;

  // Next-state decode and per-phase enables from state, wait count and decode.
  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    ien_c   = 1'b0;
    irwe_c  = 1'b0;
    den_c   = 1'b0;
    dwe_c   = 1'b0;
    rfwe_c  = 1'b0;
    pcwe_c  = 1'b0;
    sel_c   = 1'b0;
    ret_c   = 1'b0;
    case (state_q)
      S_IF: begin
        // run only matters on the first IF cycle; once a fetch is in
        // flight it completes regardless of run.
        if ((cnt_q == 3'd0) && !run) begin
          state_d = S_IF;
        end else begin
          cnt_inc = 1'b1;
          ien_c   = (cnt_q == 3'd0);
          if (cnt_q == LAT_LAST) begin
            irwe_c  = 1'b1;
            state_d = S_ID;
          end else begin
            state_d = S_IF;
          end
        end
      end
      S_ID: begin
        // Branches resolve here and skip the rest of the pipeline.
        if (is_br) begin
          pcwe_c  = 1'b1;
          sel_c   = br_taken;
          ret_c   = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        cnt_inc = 1'b1;
        if (cnt_q == 3'd0) begin
          den_c = 1'b1;
          // A load+store decode is treated as a load: no write strobe.
          dwe_c = is_st & ~is_ld;
        end else begin
          den_c = 1'b0;
        end
        if (cnt_q == LAT_LAST) begin
          if (is_ld) begin
            state_d = S_WB;
          end else begin
            pcwe_c  = 1'b1;
            sel_c   = 1'b0;
            ret_c   = 1'b1;
            state_d = S_IF;
          end
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        rfwe_c  = gr_we_dec;
        pcwe_c  = 1'b1;
        sel_c   = is_jmp;
        ret_c   = 1'b1;
        state_d = S_IF;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // Wait counter restarts on every state change, counts IF/MEM cycles.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = 3'd0;
    end else if (cnt_inc) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Retired-instruction count advances on each retire pulse and wraps.
  always_comb begin
    if (ret_c) begin
      rcnt_d = rcnt_q + CNT_W'(1);
    end else begin
      rcnt_d = rcnt_q;
    end
  end

  // State, wait counter and retire counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
      cnt_q   <= 3'd0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Enables are forced low while reset is held so an aborted instruction
  // cannot issue a request or retire.
  assign inst_sram_en = ien_c  & ~reset;
  assign ir_we        = irwe_c & ~reset;
  assign data_sram_en = den_c  & ~reset;
  assign data_sram_we = dwe_c  & ~reset;
  assign rf_we        = rfwe_c & ~reset;
  assign pc_we        = pcwe_c & ~reset;
  assign pc_sel_br    = sel_c  & ~reset;
  assign retire       = ret_c  & ~reset;
  assign state        = state_q;
  assign retire_cnt   = rcnt_q;

endmodule
